// File: rtl/axis_frame_trigger_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_frame_trigger_pkg : shared types for the trigger-gated frame source
// Rev 1.0
// ---------------------------------------------------------------------------
package axis_frame_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage : axis_frame_trigger_pkg
`default_nettype wire

// File: rtl/trigger_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_edge_detect : registers a synchronous trigger, flags its rising edge
// Rev 1.0
// ---------------------------------------------------------------------------
module trigger_edge_detect (
  input  logic aclk,
  input  logic aresetn,
  input  logic trigger_i,
  output logic edge_o
);

  logic trigger_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= trigger_i;
    end
  end

  assign edge_o = trigger_i & ~trigger_q;

endmodule : trigger_edge_detect
`default_nettype wire

// File: rtl/axis_frame_trigger.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_frame_trigger : passes trigger-aligned, fixed-length AXIS frames and
// discards input between frames. Rev 1.0
// ---------------------------------------------------------------------------
module axis_frame_trigger
  import axis_frame_trigger_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_WIDTH      = 16,
  parameter int AVERAGES_WIDTH   = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  input  logic                        trigger,
  input  logic                        start,
  input  logic                        abort,
  input  logic [FRAME_WIDTH-1:0]      cfg_frame_length,
  input  logic [AVERAGES_WIDTH-1:0]   cfg_averages,
  output logic                        busy,
  output logic                        done,
  output logic [AVERAGES_WIDTH-1:0]   frame_count
);

  state_t                    state_q, state_d;
  logic [FRAME_WIDTH-1:0]    len_q, len_d;
  logic [AVERAGES_WIDTH-1:0] avg_q, avg_d;
  logic [FRAME_WIDTH-1:0]    smp_q, smp_d;
  logic [AVERAGES_WIDTH-1:0] frm_q, frm_d;
  logic                      abort_q, abort_d;

  logic                      trig_edge;
  logic                      handshake;
  logic                      last_beat;
  logic                      abort_pending;
  logic [AVERAGES_WIDTH-1:0] frm_inc;

  trigger_edge_detect u_edge (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .trigger_i (trigger),
    .edge_o    (trig_edge)
  );

  assign handshake     = S_AXIS_tvalid & M_AXIS_tready;
  assign last_beat     = (smp_q == (len_q - FRAME_WIDTH'(1)));
  assign abort_pending = abort_q | abort;
  assign frm_inc       = frm_q + AVERAGES_WIDTH'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      avg_q   <= '0;
      smp_q   <= '0;
      frm_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      avg_q   <= avg_d;
      smp_q   <= smp_d;
      frm_q   <= frm_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    avg_d         = avg_q;
    smp_d         = smp_q;
    frm_d         = frm_q;
    abort_d       = abort_q;
    S_AXIS_tready = 1'b0;
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tlast  = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start && (cfg_frame_length != '0) && (cfg_averages != '0)) begin
          len_d   = cfg_frame_length;
          avg_d   = cfg_averages;
          frm_d   = '0;
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        S_AXIS_tready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          smp_d   = '0;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        M_AXIS_tvalid = S_AXIS_tvalid;
        S_AXIS_tready = M_AXIS_tready;
        M_AXIS_tlast  = last_beat;
        abort_d       = abort_pending;
        if (handshake) begin
          smp_d = smp_q + FRAME_WIDTH'(1);
          if (last_beat) begin
            frm_d = frm_inc;
            // A pending abort exits only here, after the frame is complete.
            if (abort_pending) begin
              state_d = ST_IDLE;
            end else if (frm_inc == avg_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign M_AXIS_tdata = S_AXIS_tdata;
  assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign frame_count  = frm_q;

endmodule : axis_frame_trigger
`default_nettype wire

// File: tb/tb_axis_frame_trigger.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_frame_trigger : scoreboard bench for axis_frame_trigger
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axis_frame_trigger;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        M_AXIS_tlast;
  logic        trigger;
  logic        start;
  logic        abort;
  logic [15:0] cfg_frame_length;
  logic [31:0] cfg_averages;
  logic        busy;
  logic        done;
  logic [31:0] frame_count;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp    = 0;
  int    n_err    = 0;
  int    done_cnt = 0;
  int    d0;

  axis_frame_trigger #(
    .AXIS_TDATA_WIDTH (32),
    .FRAME_WIDTH      (16),
    .AVERAGES_WIDTH   (32)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .S_AXIS_tdata     (S_AXIS_tdata),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tready    (S_AXIS_tready),
    .M_AXIS_tdata     (M_AXIS_tdata),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .M_AXIS_tready    (M_AXIS_tready),
    .M_AXIS_tlast     (M_AXIS_tlast),
    .trigger          (trigger),
    .start            (start),
    .abort            (abort),
    .cfg_frame_length (cfg_frame_length),
    .cfg_averages     (cfg_averages),
    .busy             (busy),
    .done             (done),
    .frame_count      (frame_count)
  );

  always #5 aclk = ~aclk;

  // Monitor: every output handshake must match the head of the expected queue.
  always @(negedge aclk) begin
    if (aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data=%0d last=%0b, required no output", M_AXIS_tdata, M_AXIS_tlast);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (M_AXIS_tdata !== e.data || M_AXIS_tlast !== e.last) begin
          n_err++;
          $display("FAIL beat: got data=%0d last=%0b, required data=%0d last=%0b",
                   M_AXIS_tdata, M_AXIS_tlast, e.data, e.last);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{data: base + 32'(i), last: (i == n - 1)});
  endtask

  task automatic do_start(input logic [15:0] len, input logic [31:0] avg);
    cfg_frame_length = len;
    cfg_averages     = avg;
    start            = 1'b1;
    step();
    start            = 1'b0;
    cfg_frame_length = 16'hFFFF;
    cfg_averages     = 32'hFFFF_FFFF;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  // Source: offers incrementing data for a number of cycles; masks schedule
  // trigger/abort levels per cycle, bp toggles the downstream ready.
  task automatic run_frame(input logic [31:0] base, input int cycles, input bit bp,
                           input logic [31:0] trig_mask, input logic [31:0] abort_mask);
    logic hs;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = base;
    for (int i = 0; i < cycles; i++) begin
      @(negedge aclk);
      hs = S_AXIS_tvalid & S_AXIS_tready;
      step();
      if (hs) S_AXIS_tdata = S_AXIS_tdata + 32'd1;
      trigger = (i < 32) ? trig_mask[i] : 1'b0;
      abort   = (i < 32) ? abort_mask[i] : 1'b0;
      if (bp) M_AXIS_tready = ~M_AXIS_tready;
    end
    S_AXIS_tvalid = 1'b0;
    trigger       = 1'b0;
    abort         = 1'b0;
    M_AXIS_tready = 1'b1;
  endtask

  initial begin
    aresetn          = 1'b0;
    S_AXIS_tdata     = '0;
    S_AXIS_tvalid    = 1'b0;
    M_AXIS_tready    = 1'b1;
    trigger          = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    cfg_frame_length = '0;
    cfg_averages     = '0;
    repeat (3) step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_tready", {31'd0, S_AXIS_tready}, 32'd0);
    chk("reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    chk("reset_frame_count", frame_count, 32'd0);
    aresetn = 1'b1;
    step();

    // Zero configuration is rejected.
    do_start(16'd0, 32'd3);
    chk("zero_len_busy", {31'd0, busy}, 32'd0);
    chk("zero_len_fc", frame_count, 32'd0);
    do_start(16'd4, 32'd0);
    chk("zero_avg_busy", {31'd0, busy}, 32'd0);
    chk("zero_avg_tready", {31'd0, S_AXIS_tready}, 32'd0);

    // Basic run: len=4, avg=2.
    do_start(16'd4, 32'd2);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    chk("basic_fc0", frame_count, 32'd0);
    repeat (5) step();
    push_frame(32'd100, 4);
    pulse_trigger();
    run_frame(32'd100, 12, 1'b0, 32'd0, 32'd0);
    chk("basic_fc1", frame_count, 32'd1);
    chk("basic_busy_armed", {31'd0, busy}, 32'd1);
    chk("basic_no_done_yet", 32'(done_cnt), 32'd0);
    repeat (8) step();
    push_frame(32'd200, 4);
    pulse_trigger();
    run_frame(32'd200, 12, 1'b0, 32'd0, 32'd0);
    chk("basic_fc2", frame_count, 32'd2);
    chk("basic_idle", {31'd0, busy}, 32'd0);
    chk("basic_done_once", 32'(done_cnt), 32'd1);

    // Back-to-back: trigger in the one-cycle re-arm window is honored;
    // one sample is drained during that cycle.
    d0 = done_cnt;
    do_start(16'd3, 32'd2);
    push_frame(32'd300, 3);
    push_frame(32'd304, 3);
    pulse_trigger();
    run_frame(32'd300, 14, 1'b0, 32'h0000_0004, 32'd0);
    chk("b2b_fc", frame_count, 32'd2);
    chk("b2b_done", 32'(done_cnt - d0), 32'd1);

    // Ignored triggers: in IDLE, mid-capture, and on the last beat.
    pulse_trigger();
    repeat (2) step();
    do_start(16'd4, 32'd2);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_fc_cleared", frame_count, 32'd0);
    run_frame(32'd350, 4, 1'b0, 32'd0, 32'd0);
    push_frame(32'd400, 4);
    pulse_trigger();
    run_frame(32'd400, 12, 1'b0, 32'h0000_000D, 32'd0);
    chk("ign_fc", frame_count, 32'd1);
    chk("ign_still_armed", {31'd0, busy}, 32'd1);
    // Abort while ARMED returns to IDLE next cycle.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_armed_idle", {31'd0, busy}, 32'd0);

    // Abort mid-frame: frame completes, then IDLE without done.
    d0 = done_cnt;
    do_start(16'd5, 32'd3);
    push_frame(32'd500, 5);
    pulse_trigger();
    run_frame(32'd500, 14, 1'b0, 32'd0, 32'h0000_0002);
    chk("abort_cap_fc", frame_count, 32'd1);
    chk("abort_cap_idle", {31'd0, busy}, 32'd0);
    chk("abort_cap_no_done", 32'(done_cnt - d0), 32'd0);

    // Backpressure: len=8 with downstream ready toggling.
    d0 = done_cnt;
    do_start(16'd8, 32'd1);
    push_frame(32'd800, 8);
    pulse_trigger();
    run_frame(32'd800, 22, 1'b1, 32'd0, 32'd0);
    chk("bp_fc", frame_count, 32'd1);
    chk("bp_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-frame at beat 3, then a clean frame.
    do_start(16'd6, 32'd1);
    push_frame(32'd600, 3);
    exp_q[exp_q.size() - 1].last = 1'b0;
    pulse_trigger();
    run_frame(32'd600, 3, 1'b0, 32'd0, 32'd0);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'd603;
    #1;
    chk("pre_reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    chk("rst_tready", {31'd0, S_AXIS_tready}, 32'd0);
    chk("rst_tlast", {31'd0, M_AXIS_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fc", frame_count, 32'd0);
    S_AXIS_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    d0 = done_cnt;
    do_start(16'd6, 32'd1);
    push_frame(32'd700, 6);
    pulse_trigger();
    run_frame(32'd700, 16, 1'b0, 32'd0, 32'd0);
    chk("post_rst_fc", frame_count, 32'd1);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axis_frame_trigger
`default_nettype wire
